// File: rtl/regfile_checker_if.sv
// Bus bundle for regfile_checker: start/length control, observed writeback,
// regfile port-A mux, expected-value lookup, status and trace stream.
// master = checker side, slave = environment (CPU, regfile, expected table).
interface regfile_checker_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned CYCLE_WIDTH = 16
);
    logic                   start;
    logic [CYCLE_WIDTH-1:0] num_cycles;
    logic                   rwe;
    logic [ADDR_WIDTH-1:0]  rd;
    logic [DATA_WIDTH-1:0]  rData;
    logic [ADDR_WIDTH-1:0]  rs1_cpu;
    logic [DATA_WIDTH-1:0]  regA;
    logic [ADDR_WIDTH-1:0]  rs1_out;
    logic [ADDR_WIDTH-1:0]  exp_addr;
    logic [DATA_WIDTH-1:0]  exp_data;
    logic                   test_mode;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ADDR_WIDTH:0]    error_count;
    logic [ADDR_WIDTH-1:0]  first_fail;
    logic                   trace_valid;
    logic                   trace_ready;
    logic [CYCLE_WIDTH-1:0] trace_cycle;
    logic [ADDR_WIDTH-1:0]  trace_reg;
    logic [DATA_WIDTH-1:0]  trace_data;
    logic                   trace_overflow;

    modport master (
        input  start, num_cycles, rwe, rd, rData, rs1_cpu, regA, exp_data, trace_ready,
        output rs1_out, exp_addr, test_mode, busy, done, pass, error_count, first_fail,
               trace_valid, trace_cycle, trace_reg, trace_data, trace_overflow
    );

    modport slave (
        output start, num_cycles, rwe, rd, rData, rs1_cpu, regA, exp_data, trace_ready,
        input  rs1_out, exp_addr, test_mode, busy, done, pass, error_count, first_fail,
               trace_valid, trace_cycle, trace_reg, trace_data, trace_overflow
    );
endinterface

// File: rtl/regfile_checker.sv
// Register-file checker: observes CPU writebacks for num_cycles cycles (RUN),
// then sweeps every register through port A comparing against an expected
// table (SCAN), and reports pass/error_count/first_fail in DONE.
// Optional trace FIFO of logged writebacks is enabled by defining
// CHECKER_TRACE_EN; without it the trace outputs are tied to zero.
module regfile_checker #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned CYCLE_WIDTH = 16,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    regfile_checker_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SCAN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] len_q, len_d;
    logic [CYCLE_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [ADDR_WIDTH:0]    err_q, err_d;
    logic [ADDR_WIDTH-1:0]  ff_q, ff_d;

    logic start_acc;
    logic run_last;
    logic scan_last;

    assign start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign run_last  = (cnt_q == (len_q - CYCLE_WIDTH'(1)));
    assign scan_last = (idx_q == ADDR_WIDTH'(NUM_REGS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) state_d = (bus.num_cycles == '0) ? S_SCAN : S_RUN;
            end
            S_RUN:  if (run_last)  state_d = S_SCAN;
            S_SCAN: if (scan_last) state_d = S_DONE;
        endcase
    end

    // Status and port-A mux outputs
    always_comb begin
        bus.busy        = (state_q == S_RUN) || (state_q == S_SCAN);
        bus.test_mode   = (state_q == S_SCAN);
        bus.done        = (state_q == S_DONE);
        bus.pass        = (state_q == S_DONE) && (err_q == '0);
        bus.rs1_out     = (state_q == S_SCAN) ? idx_q : bus.rs1_cpu;
        bus.exp_addr    = idx_q;
        bus.error_count = err_q;
        bus.first_fail  = ff_q;
    end

    // Counter, scan index and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            err_q <= '0;
            ff_q  <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            err_q <= err_d;
            ff_q  <= ff_d;
        end
    end

    // Datapath next-state: run counting, scan sweep and mismatch accounting
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        err_d = err_q;
        ff_d  = ff_q;
        if (start_acc) begin
            len_d = bus.num_cycles;
            cnt_d = '0;
            idx_d = '0;
            err_d = '0;
            ff_d  = '0;
        end else if (state_q == S_RUN) begin
            if (!run_last) cnt_d = cnt_q + CYCLE_WIDTH'(1);
        end else if (state_q == S_SCAN) begin
            if (bus.regA != bus.exp_data) begin
                err_d = err_q + (ADDR_WIDTH + 1)'(1);
                if (err_q == '0) ff_d = idx_q;
            end
            if (!scan_last) idx_d = idx_q + ADDR_WIDTH'(1);
        end
    end

`ifdef CHECKER_TRACE_EN
    localparam int unsigned PTR_W   = $clog2(TRACE_DEPTH);
    localparam int unsigned FILL_W  = PTR_W + 1;
    localparam int unsigned ENTRY_W = CYCLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               ovf_q, ovf_d;
    logic               push, pop, full, do_write;

    assign push     = (state_q == S_RUN) && bus.rwe && (bus.rd != '0);
    assign full     = (fill_q == FILL_W'(TRACE_DEPTH));
    assign pop      = (fill_q != '0) && bus.trace_ready;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_write = push && (!full || pop);

    // Trace storage (no reset needed; occupancy qualifies the contents)
    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_q] <= {cnt_q, bus.rd, bus.rData};
    end

    // Trace pointer, occupancy and overflow registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    // Trace next-state: flush on accepted start, else push/pop bookkeeping
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        if (start_acc) begin
            wr_d   = '0;
            rd_d   = '0;
            fill_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (do_write) wr_d = wr_q + PTR_W'(1);
            if (pop)      rd_d = rd_q + PTR_W'(1);
            fill_d = fill_q + FILL_W'(do_write) - FILL_W'(pop);
            if (push && !do_write) ovf_d = 1'b1;
        end
    end

    assign bus.trace_valid    = (fill_q != '0);
    assign bus.trace_overflow = ovf_q;
    assign {bus.trace_cycle, bus.trace_reg, bus.trace_data} = mem_q[rd_q];
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = ^{bus.rwe, bus.rd, bus.rData, bus.trace_ready};

    assign bus.trace_valid    = 1'b0;
    assign bus.trace_overflow = 1'b0;
    assign bus.trace_cycle    = '0;
    assign bus.trace_reg      = '0;
    assign bus.trace_data     = '0;
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// Self-checking bench for regfile_checker: directed run/scan sequences with
// randomized writebacks, register contents and trace back-pressure, checked
// against array/queue-based expectations. Trace checks follow CHECKER_TRACE_EN.
`timescale 1ns/1ps
module tb_regfile_checker;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;
    localparam int unsigned TD = 16;
    localparam int unsigned EW = CW + AW + DW;
`ifdef CHECKER_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_checker_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CYCLE_WIDTH(CW)) bus ();

    regfile_checker #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
        .CYCLE_WIDTH(CW), .TRACE_DEPTH(TD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Environment: register file contents and expected-value table
    logic [DW-1:0] rf   [NR];
    logic [DW-1:0] expv [NR];
    assign bus.regA     = rf[bus.rs1_out];
    assign bus.exp_data = expv[bus.exp_addr];

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] tq[$];
    bit            ovf_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic trace_checks();
        check("trace_valid", 64'(bus.trace_valid), 64'(tq.size() > 0));
        if (tq.size() > 0)
            check("trace_head", 64'({bus.trace_cycle, bus.trace_reg, bus.trace_data}), 64'(tq[0]));
        check("trace_overflow", 64'(bus.trace_overflow), 64'(ovf_exp));
    endtask

    // Reference FIFO behaviour for the coming clock edge
    task automatic trace_model(input bit push, input logic [EW-1:0] e);
        bit pop;
        bit acc;
        pop = bus.trace_ready && (tq.size() > 0);
        acc = 1'b0;
        if (TRACE_ON && push) begin
            if ((tq.size() < TD) || pop) acc = 1'b1;
            else ovf_exp = 1'b1;
        end
        if (pop) void'(tq.pop_front());
        if (acc) tq.push_back(e);
    endtask

    task automatic fill_regs();
        for (int i = 0; i < NR; i++) begin
            rf[i]   = $urandom;
            expv[i] = rf[i];
        end
    endtask

    task automatic flip(input int idx);
        expv[idx] = expv[idx] ^ (32'h1 << $urandom_range(DW - 1, 0));
    endtask

    task automatic run_test(input string name, input int unsigned ncyc, input int unsigned wpct,
                            input int unsigned rpct, input bit nonzero_rd, input bit mid_start,
                            input bit force_w);
        int unsigned   exp_err;
        int unsigned   exp_ff;
        bit            w;
        logic [AW-1:0] rdv;
        logic [DW-1:0] dv;
        exp_err = 0;
        exp_ff  = 0;
        for (int i = 0; i < NR; i++) begin
            if (rf[i] != expv[i]) begin
                if (exp_err == 0) exp_ff = i;
                exp_err++;
            end
        end
        // Start pulse (accepted from IDLE or DONE)
        trace_checks();
        bus.start       = 1'b1;
        bus.num_cycles  = CW'(ncyc);
        bus.trace_ready = 1'b0;
        tq.delete();
        ovf_exp = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        // RUN phase
        for (int k = 0; k < int'(ncyc); k++) begin
            check({name, ".run_busy"}, 64'(bus.busy), 64'(1));
            check({name, ".run_test_mode"}, 64'(bus.test_mode), 64'(0));
            check({name, ".run_rs1_out"}, 64'(bus.rs1_out), 64'(bus.rs1_cpu));
            trace_checks();
            bus.rs1_cpu = AW'($urandom_range(NR - 1, 0));
            bus.start   = mid_start && (k == 1);
            w   = ($urandom_range(99, 0) < wpct);
            rdv = nonzero_rd ? AW'($urandom_range(NR - 1, 1)) : AW'($urandom_range(NR - 1, 0));
            dv  = $urandom;
            if (force_w) begin
                w   = (k == 2);
                rdv = AW'(3);
                dv  = 32'd7;
            end
            bus.rwe   = w;
            bus.rd    = rdv;
            bus.rData = dv;
            bus.trace_ready = ($urandom_range(99, 0) < rpct);
            trace_model(w && (rdv != '0), {CW'(k), rdv, dv});
            @(negedge clock);
        end
        bus.start = 1'b0;
        // SCAN phase: writebacks here must not be logged
        for (int i = 0; i < NR; i++) begin
            check({name, ".scan_test_mode"}, 64'(bus.test_mode), 64'(1));
            check({name, ".scan_busy"}, 64'(bus.busy), 64'(1));
            check({name, ".scan_rs1_out"}, 64'(bus.rs1_out), 64'(i));
            check({name, ".scan_exp_addr"}, 64'(bus.exp_addr), 64'(i));
            trace_checks();
            bus.rwe   = 1'($urandom_range(1, 0));
            bus.rd    = AW'($urandom_range(NR - 1, 1));
            bus.rData = $urandom;
            bus.trace_ready = ($urandom_range(99, 0) < rpct);
            trace_model(1'b0, '0);
            @(negedge clock);
        end
        bus.rwe = 1'b0;
        // DONE: results hold while the trace FIFO drains
        for (int h = 0; h < int'(TD) + 3; h++) begin
            check({name, ".done"}, 64'(bus.done), 64'(1));
            check({name, ".done_busy"}, 64'(bus.busy), 64'(0));
            check({name, ".done_test_mode"}, 64'(bus.test_mode), 64'(0));
            check({name, ".pass"}, 64'(bus.pass), 64'(exp_err == 0));
            check({name, ".error_count"}, 64'(bus.error_count), 64'(exp_err));
            check({name, ".first_fail"}, 64'(bus.first_fail), 64'(exp_ff));
            check({name, ".done_rs1_out"}, 64'(bus.rs1_out), 64'(bus.rs1_cpu));
            trace_checks();
            bus.rs1_cpu     = AW'($urandom_range(NR - 1, 0));
            bus.trace_ready = (h > 0);
            trace_model(1'b0, '0);
            @(negedge clock);
        end
        bus.trace_ready = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.num_cycles  = '0;
        bus.rwe         = 1'b0;
        bus.rd          = '0;
        bus.rData       = '0;
        bus.rs1_cpu     = AW'(13);
        bus.trace_ready = 1'b0;
        ovf_exp         = 1'b0;
        fill_regs();
        repeat (2) @(negedge clock);

        // Reset state
        check("rst.busy", 64'(bus.busy), 64'(0));
        check("rst.done", 64'(bus.done), 64'(0));
        check("rst.pass", 64'(bus.pass), 64'(0));
        check("rst.test_mode", 64'(bus.test_mode), 64'(0));
        check("rst.error_count", 64'(bus.error_count), 64'(0));
        check("rst.first_fail", 64'(bus.first_fail), 64'(0));
        check("rst.exp_addr", 64'(bus.exp_addr), 64'(0));
        check("rst.rs1_out", 64'(bus.rs1_out), 64'(13));
        trace_checks();
        reset = 1'b0;
        @(negedge clock);

        // Five-cycle run, single write at cycle 2, errors at 4 and 9, ignored mid-run start
        fill_regs();
        flip(4);
        flip(9);
        run_test("basic", 5, 0, 0, 1'b1, 1'b1, 1'b1);

        // Twenty logged writes with no draining: first 16 kept, overflow set
        fill_regs();
        run_test("ovf", 20, 100, 0, 1'b1, 1'b0, 1'b0);

        // Zero-length run goes straight to SCAN
        fill_regs();
        for (int i = 0; i < NR; i++) if ($urandom_range(7, 0) == 0) flip(i);
        run_test("zero", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-SCAN at index 10
        fill_regs();
        flip(2);
        bus.start = 1'b1;
        bus.num_cycles = CW'(3);
        @(negedge clock);
        bus.start = 1'b0;
        bus.rwe = 1'b1;
        bus.rd = AW'(5);
        bus.rData = 32'hABCD;
        repeat (3) @(negedge clock);
        bus.rwe = 1'b0;
        repeat (10) @(negedge clock);
        check("rstscan.rs1_out", 64'(bus.rs1_out), 64'(10));
        check("rstscan.err_before", 64'(bus.error_count), 64'(1));
        reset = 1'b1;
        bus.rs1_cpu = AW'(21);
        @(negedge clock);
        tq.delete();
        ovf_exp = 1'b0;
        check("rstscan.busy", 64'(bus.busy), 64'(0));
        check("rstscan.done", 64'(bus.done), 64'(0));
        check("rstscan.test_mode", 64'(bus.test_mode), 64'(0));
        check("rstscan.error_count", 64'(bus.error_count), 64'(0));
        check("rstscan.first_fail", 64'(bus.first_fail), 64'(0));
        check("rstscan.exp_addr", 64'(bus.exp_addr), 64'(0));
        check("rstscan.rs1_out", 64'(bus.rs1_out), 64'(21));
        trace_checks();

        // Reset wins over start in the same cycle
        bus.start = 1'b1;
        bus.num_cycles = CW'(4);
        @(negedge clock);
        reset = 1'b0;
        bus.start = 1'b0;
        check("rststart.busy", 64'(bus.busy), 64'(0));
        @(negedge clock);
        check("rststart.busy_hold", 64'(bus.busy), 64'(0));
        check("rststart.done", 64'(bus.done), 64'(0));

        // Boundary indices 0 and 31 (MSB) mismatch, rd=0 writes possible, random drain
        fill_regs();
        flip(0);
        expv[NR - 1] = expv[NR - 1] ^ 32'h8000_0000;
        for (int i = 1; i < int'(NR) - 1; i++) if ($urandom_range(5, 0) == 0) flip(i);
        run_test("edges", 12, 60, 50, 1'b0, 1'b0, 1'b0);

        // Long run with concurrent push/pop near full
        fill_regs();
        for (int i = 0; i < NR; i++) if ($urandom_range(3, 0) == 0) flip(i);
        run_test("long", 40, 90, 40, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
